neurram_reg_sched: RTL and testbench
====================================

// Module: neurram_reg_sched
// PURPOSE
//  Arbitrates four requesters sharing the register-chain clocking controller: SPI shift, random access,
//  neuron read 0 and neuron read 1. Issues one trigger at a time, tracks completion (SPI via
//  state_spi_idle, others by fixed count), then enforces an inter-op gap. Sits between the host/core
//  sequencers and the register-chain clock controller.
// PARAMETERS
//  NREQ      4   requesters (fixed order: 0=SPI, 1=RAND, 2=NRD0, 3=NRD1)
//  GAP_CYC   4   idle cycles after every op before the next grant (>=1)
//  PULSE_CYC 2   cycles a non-SPI op counts as busy after its trigger
//  TO_CYC    4096 SPI start/finish timeout in cycles (used only with NEURRAM_REG_SCHED_TIMEOUT_EN)
// PORTS
//  clk                  in   1   system clock
//  rst_n                in   1   asynchronous active-low reset
//  req                  in   4   per-requester request, level, held until ack
//  ack                  out  4   one-hot, 1-cycle pulse when that requester's op completes
//  grant                out  4   one-hot, high from issue through completion
//  spi_trigger          out  1   1-cycle pulse to the controller
//  rand_access_trigger  out  1   1-cycle pulse
//  neuron_read_trigger  out  2   1-cycle pulse, one-hot
//  state_spi_idle       in   1   SPI engine idle flag
//  busy                 out  1   high whenever state != IDLE
//  timeout              out  1   sticky error flag (0 when feature absent)
// BEHAVIOUR
//  Reset (rst_n low, any time): all outputs 0, state IDLE, rr_ptr=0, counters 0; an in-flight op is
//   abandoned with no ack.
//  Arbitration: round-robin starting at rr_ptr; the winner sets rr_ptr=winner+1 (mod 4).
//  FSM:
//   IDLE   : if |req -> latch winner, grant[w]=1 -> ISSUE
//   ISSUE  : pulse the matching trigger for exactly 1 cycle; SPI -> WAIT_S, else cnt=PULSE_CYC -> WAIT_F
//   WAIT_S : wait for state_spi_idle==0 (engine started) -> WAIT_D
//   WAIT_D : wait for state_spi_idle==1 -> DONE
//   WAIT_F : decrement cnt; at 1 -> DONE
//   DONE   : ack[w]=1 for 1 cycle, grant cleared, cnt=GAP_CYC -> GAP
//   GAP    : decrement cnt; at 1 -> IDLE (req is not sampled during GAP)
//  Latency: req rising in IDLE -> trigger 2 cycles later (registered grant, registered trigger).
//  At most one trigger bit is high in any cycle; triggers are never asserted outside ISSUE.
//  A req dropped before ack: the op still runs to completion and the ack is still issued.
//  A requester re-asserting req on the ack cycle is eligible only after GAP; round-robin keeps it behind
//   other pending requesters.
//  Simultaneous requests: one grant per op; no requester waits more than 3 ops.
//  All counters are wide enough for the larger of GAP_CYC, PULSE_CYC and TO_CYC; no wrap in normal use.
// CONFIGURATION
//  NEURRAM_REG_SCHED_TIMEOUT_EN defined:
//   - a counter runs in WAIT_S and WAIT_D and reloads on each state entry.
//   - reaching TO_CYC sets timeout (sticky until reset), pulses ack[w] and goes -> GAP.
//  Not defined:
//   - timeout is tied to 0; WAIT_S and WAIT_D wait indefinitely; no timeout counter is synthesised.
// STRUCTURE
//  neurram_reg_pkg: state encodings, requester index constants REQ_SPI/REQ_RAND/REQ_NRD0/REQ_NRD1.
//  Sub-module neurram_rr_arbiter (4-way round-robin: req, rr_ptr -> one-hot winner), combinational.
//  Top level: FSM, counters, trigger decode.
// TESTING
//  1 Single req[1] -> rand_access_trigger pulses once; ack[1] after PULSE_CYC+1 cycles; busy low after GAP.
//  2 req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; each req acked once per round.
//  3 SPI op: state_spi_idle drops 3 cycles after trigger and rises 20 cycles later -> ack[0] the cycle
//    after the rise.
//  4 rst_n low during WAIT_D -> all outputs 0 immediately; no ack; the next req is served normally.
//  5 (TIMEOUT_EN, TO_CYC=16) state_spi_idle stuck at 1 -> timeout=1 and ack[0] 16 cycles after WAIT_S
//    entry.
//  6 req[2] dropped 1 cycle after grant -> neuron_read_trigger=2'b01 pulses once; ack[2] is still
//    issued.

Source files
------------

// File: rtl/neurram_reg_pkg.sv
// Shared definitions for the register-chain scheduler: requester indices,
// FSM state encoding and counter-sizing helpers.
package neurram_reg_pkg;

  localparam int NREQ  = 4;
  localparam int PTR_W = $clog2(NREQ);

  // Fixed requester order
  localparam int REQ_SPI  = 0;
  localparam int REQ_RAND = 1;
  localparam int REQ_NRD0 = 2;
  localparam int REQ_NRD1 = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT_S = 3'd2,
    ST_WAIT_D = 3'd3,
    ST_WAIT_F = 3'd4,
    ST_DONE   = 3'd5,
    ST_GAP    = 3'd6
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..maxval inclusive
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/neurram_rr_arbiter.sv
// Combinational 4-way round-robin arbiter: scans req starting at rr_ptr and
// returns the first asserted requester as a one-hot grant plus its index.
module neurram_rr_arbiter
  import neurram_reg_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  winner,
  output logic [PTR_W-1:0] winner_idx,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  // First requester at or after rr_ptr (wrapping) wins
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = rr_ptr + PTR_W'(off);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        winner_idx = idx;
        winner     = NREQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/neurram_reg_sched.sv
// Register-chain scheduler: arbitrates SPI shift, random access and the two
// neuron reads onto the shared chain clock controller, one op at a time,
// tracks completion and enforces an inter-op gap.
// Optional SPI start/finish timeout: define NEURRAM_REG_SCHED_TIMEOUT_EN.
module neurram_reg_sched
  import neurram_reg_pkg::*;
#(
  parameter int GAP_CYC   = 4,
  parameter int PULSE_CYC = 2,
  parameter int TO_CYC    = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] grant,
  output logic            spi_trigger,
  output logic            rand_access_trigger,
  output logic [1:0]      neuron_read_trigger,
  input  logic            state_spi_idle,
  output logic            busy,
  output logic            timeout
);

  localparam int CNT_W = cnt_width(max3(GAP_CYC, PULSE_CYC, TO_CYC));

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  trig_q, trig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  arb_grant;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_valid;
  logic             to_hit;

  neurram_rr_arbiter u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .winner     (arb_grant),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  // Next-state, grant/ack/trigger and op/gap counter logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    ack_d    = '0;
    trig_d   = '0;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d  = arb_grant;
          rr_ptr_d = arb_idx + PTR_W'(1);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Trigger is registered, so it pulses on the cycle after ISSUE
        trig_d = grant_q;
        if (grant_q[REQ_SPI]) begin
          state_d = ST_WAIT_S;
        end else begin
          cnt_d   = CNT_W'(PULSE_CYC);
          state_d = ST_WAIT_F;
        end
      end
      ST_WAIT_S: begin
        if (!state_spi_idle) begin
          state_d = ST_WAIT_D;
        end else if (to_hit) begin
          ack_d   = grant_q;
          grant_d = '0;
          cnt_d   = CNT_W'(GAP_CYC);
          state_d = ST_GAP;
        end
      end
      ST_WAIT_D: begin
        if (state_spi_idle) begin
          ack_d   = grant_q;
          state_d = ST_DONE;
        end else if (to_hit) begin
          ack_d   = grant_q;
          grant_d = '0;
          cnt_d   = CNT_W'(GAP_CYC);
          state_d = ST_GAP;
        end
      end
      ST_WAIT_F: begin
        if (cnt_q <= CNT_W'(1)) begin
          ack_d   = grant_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        grant_d = '0;
        cnt_d   = CNT_W'(GAP_CYC);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight op silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      trig_q   <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      trig_q   <= trig_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef NEURRAM_REG_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;

  assign to_hit = ((state_q == ST_WAIT_S) || (state_q == ST_WAIT_D)) &&
                  (to_cnt_q == CNT_W'(TO_CYC));

  // Timeout counter reloads on entry to each SPI wait state; flag is sticky
  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q | (to_hit && (state_d == ST_GAP));
    if ((state_d == ST_WAIT_S) || (state_d == ST_WAIT_D)) begin
      if (state_d != state_q) begin
        to_cnt_d = CNT_W'(1);
      end else begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
      end
    end
  end

  // Timeout counter and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign ack                 = ack_q;
  assign grant               = grant_q;
  assign spi_trigger         = trig_q[REQ_SPI];
  assign rand_access_trigger = trig_q[REQ_RAND];
  assign neuron_read_trigger = trig_q[REQ_NRD1:REQ_NRD0];
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neurram_reg_sched.sv
// Self-checking bench for neurram_reg_sched: table of single ops, round-robin
// sequence, dropped request, reset mid-op and (optionally) SPI timeout.
module tb_neurram_reg_sched;
  import neurram_reg_pkg::*;

  localparam int GAP_CYC   = 4;
  localparam int PULSE_CYC = 2;
  localparam int TO_CYC    = 16;
  localparam int SPI_START = 3;
`ifdef NEURRAM_REG_SCHED_TIMEOUT_EN
  localparam int SPI_RUN   = 10;
`else
  localparam int SPI_RUN   = 20;
`endif
  // req driven -> ack seen, in cycles
  localparam int LAT_F = 2 + PULSE_CYC;
  localparam int LAT_S = 2 + SPI_START + 1 + SPI_RUN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       state_spi_idle = 1'b1;
  logic [3:0] ack, grant;
  logic       spi_trigger, rand_access_trigger, busy, timeout;
  logic [1:0] neuron_read_trigger;

  neurram_reg_sched #(
    .GAP_CYC   (GAP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .TO_CYC    (TO_CYC)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req                 (req),
    .ack                 (ack),
    .grant               (grant),
    .spi_trigger         (spi_trigger),
    .rand_access_trigger (rand_access_trigger),
    .neuron_read_trigger (neuron_read_trigger),
    .state_spi_idle      (state_spi_idle),
    .busy                (busy),
    .timeout             (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor state
  int   exp_q[$];
  int   grant_log[$];
  int   ack_cnt = 0;
  int   last_ack_cyc = 0;
  int   trig_cnt[4];
  logic [1:0] last_nrd = '0;
  bit   spi_stuck = 1'b0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every ack, cross-checks triggers vs grant
  initial begin : monitor
    logic [3:0] prev_grant;
    logic [3:0] trig_vec;
    int         exp_idx;
    prev_grant = '0;
    for (int i = 0; i < 4; i++) trig_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack != '0) begin
          ack_cnt++;
          last_ack_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("ack_unexpected", {28'd0, ack}, 32'd0);
          end else begin
            exp_idx = exp_q.pop_front();
            check("ack_onehot", {28'd0, ack}, 32'd1 << exp_idx);
          end
        end
        trig_vec = {neuron_read_trigger, rand_access_trigger, spi_trigger};
        if (trig_vec != '0) begin
          for (int i = 0; i < 4; i++) trig_cnt[i] += int'(trig_vec[i]);
          if (trig_vec[3:2] != 2'b00) last_nrd = trig_vec[3:2];
          check("trig_matches_grant", {28'd0, trig_vec}, {28'd0, grant});
        end
        if (grant != '0 && prev_grant == '0) begin
          for (int i = 0; i < 4; i++) if (grant[i]) grant_log.push_back(i);
        end
        prev_grant = grant;
      end else begin
        prev_grant = '0;
      end
    end
  end

  // SPI engine model: leaves idle SPI_START cycles after a trigger, returns SPI_RUN later
  initial begin : spi_model
    forever begin
      @(negedge clk);
      if (spi_trigger && !spi_stuck) begin
        repeat (SPI_START) @(posedge clk);
        #1 state_spi_idle = 1'b0;
        repeat (SPI_RUN) @(posedge clk);
        #1 state_spi_idle = 1'b1;
      end
    end
  end

  task automatic wait_idle(input string name, output int idle_cyc);
    int n;
    n = 0;
    step();
    while (busy && n < 300) begin
      step();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    idle_cyc = cyc;
  endtask

  task automatic wait_acks(input int target, input string name);
    int n;
    n = 0;
    while (ack_cnt < target && n < 600) begin
      step();
      n++;
    end
    check(name, ack_cnt, target);
  endtask

  // One op from IDLE: latency, trigger count and gap length are all checked
  task automatic run_single(input logic [3:0] req_bits, input int exp_idx,
                            input int exp_lat, input string name);
    int c0, acks0, idle_cyc, sum;
    wait_idle({name, "_pre_idle"}, idle_cyc);
    @(posedge clk);
    #1;
    c0    = cyc;
    acks0 = ack_cnt;
    for (int i = 0; i < 4; i++) trig_cnt[i] = 0;
    exp_q.push_back(exp_idx);
    req = req_bits;
    wait_acks(acks0 + 1, {name, "_acked"});
    check({name, "_latency"}, last_ack_cyc - c0, exp_lat);
    req = '0;
    wait_idle({name, "_idle"}, idle_cyc);
    check({name, "_gap"}, idle_cyc - last_ack_cyc, GAP_CYC + 1);
    sum = 0;
    for (int i = 0; i < 4; i++) sum += trig_cnt[i];
    check({name, "_trig_once"}, trig_cnt[exp_idx], 1);
    check({name, "_trig_total"}, sum, 1);
  endtask

  typedef struct {
    logic [3:0] req;
    int         exp_idx;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    int idle_cyc, acks0, n, c0;
    logic [31:0] order;

    // Round-robin pointer evolves across entries: starts at 1 after the RR sequence
    vecs[0] = '{4'b0010, REQ_RAND, LAT_F};
    vecs[1] = '{4'b0001, REQ_SPI,  LAT_S};
    vecs[2] = '{4'b0101, REQ_NRD0, LAT_F};
    vecs[3] = '{4'b1001, REQ_NRD1, LAT_F};
    vecs[4] = '{4'b1001, REQ_SPI,  LAT_S};
    vecs[5] = '{4'b1000, REQ_NRD1, LAT_F};
    vecs[6] = '{4'b0110, REQ_RAND, LAT_F};
    vecs[7] = '{4'b0110, REQ_NRD0, LAT_F};
    vecs[8] = '{4'b1111, REQ_NRD1, LAT_F};
    vecs[9] = '{4'b0100, REQ_NRD0, LAT_F};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {20'd0, ack, grant, spi_trigger, rand_access_trigger, neuron_read_trigger, busy, timeout},
          32'd0);
    rst_n = 1'b1;

    // All four held from rr_ptr=0: grants 0,1,2,3,0
    wait_idle("rr_pre_idle", idle_cyc);
    @(posedge clk);
    #1;
    grant_log.delete();
    acks0 = ack_cnt;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    req = 4'b1111;
    wait_acks(acks0 + 5, "rr_five_acks");
    req = '0;
    wait_idle("rr_idle", idle_cyc);
    check("rr_grant_count", grant_log.size(), 5);
    order = '0;
    for (int i = 0; i < 5 && i < grant_log.size(); i++) order = (order << 4) | 32'(grant_log[i]);
    check("rr_grant_order", order, 32'h01230);

    // Table of single ops
    for (int v = 0; v < 10; v++) begin
      run_single(vecs[v].req, vecs[v].exp_idx, vecs[v].exp_lat, $sformatf("vec%0d", v));
    end

    // req[2] dropped one cycle after grant: op still completes and is acked
    wait_idle("drop_pre_idle", idle_cyc);
    @(posedge clk);
    #1;
    acks0 = ack_cnt;
    for (int i = 0; i < 4; i++) trig_cnt[i] = 0;
    last_nrd = '0;
    exp_q.push_back(REQ_NRD0);
    req = 4'b0100;
    n = 0;
    while (grant == '0 && n < 20) begin
      step();
      n++;
    end
    check("drop_grant", {28'd0, grant}, 32'h4);
    @(posedge clk);
    #1;
    req = '0;
    wait_acks(acks0 + 1, "drop_acked");
    wait_idle("drop_idle", idle_cyc);
    check("drop_trig_once", trig_cnt[REQ_NRD0], 1);
    check("drop_nrd_value", {30'd0, last_nrd}, 32'h1);

    // Reset during WAIT_D: outputs clear at once, no ack, next op served normally
    @(posedge clk);
    #1;
    acks0 = ack_cnt;
    req = 4'b0001;
    n = 0;
    while (state_spi_idle && n < 40) begin
      step();
      n++;
    end
    check("rst_spi_started", {31'd0, state_spi_idle}, 32'd0);
    repeat (4) step();
    @(posedge clk);
    #1;
    req   = '0;
    rst_n = 1'b0;
    #1;
    check("rst_outputs_cleared",
          {20'd0, ack, grant, spi_trigger, rand_access_trigger, neuron_read_trigger, busy, timeout},
          32'd0);
    n = 0;
    while (!state_spi_idle && n < 60) begin
      step();
      n++;
    end
    repeat (3) step();
    check("rst_no_ack", ack_cnt, acks0);
    check("rst_scoreboard_empty", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_single(4'b0010, REQ_RAND, LAT_F, "post_rst");

`ifdef NEURRAM_REG_SCHED_TIMEOUT_EN
    // SPI engine never leaves idle: timeout and ack TO_CYC cycles after WAIT_S entry
    spi_stuck = 1'b1;
    wait_idle("to_pre_idle", idle_cyc);
    @(posedge clk);
    #1;
    c0    = cyc;
    acks0 = ack_cnt;
    exp_q.push_back(REQ_SPI);
    req = 4'b0001;
    wait_acks(acks0 + 1, "to_acked");
    check("to_latency", last_ack_cyc - c0, 2 + TO_CYC);
    check("to_flag", {31'd0, timeout}, 32'd1);
    req = '0;
    wait_idle("to_idle", idle_cyc);
    check("to_sticky", {31'd0, timeout}, 32'd1);
    spi_stuck = 1'b0;
`else
    c0 = cyc;
    check("timeout_absent", {31'd0, timeout}, 32'd0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
